// File: rtl/mem_sequencer_if.sv
// Shared instruction/data memory port between mem_sequencer (master) and the memory (slave).
// Valid/ready: mem_req with its attributes holds stable until the cycle mem_ready=1 completes it.
interface mem_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_sequencer.sv
// Multi-phase sequencer running a single-cycle RV32I datapath over one shared memory port:
// fetch, decode settle, optional load/store, then a one-cycle commit strobe.
module mem_sequencer #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_addr,
    input  logic [31:0]  d_wdata,
    input  logic [3:0]   d_wstrb,
    output logic [31:0]  instr,
    output logic [31:0]  d_rdata,
    output logic         commit,
    output logic         bus_err,
    output logic [2:0]   dbg_state,
    mem_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_EXEC    = 3'd1,
        S_DATA_RD = 3'd2,
        S_DATA_WR = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    // A request that is still unanswered in the cycle holding this count has timed out.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_c;
    logic        we_c;
    logic [31:0] addr_c;
    logic [31:0] wdata_c;
    logic [3:0]  wstrb_c;
    logic        commit_c;
    logic        expired;

    assign expired = (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 16'd0;
            instr_q <= NOP_INSTR;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        rdata_d  = rdata_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = 32'd0;
        wdata_c  = 32'd0;
        wstrb_c  = 4'd0;
        commit_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc;
                if (bus.mem_ready) begin
                    instr_d = bus.mem_rdata;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (expired) state_d = S_HALT;
                end
            end
            S_EXEC: begin
                // A store takes priority when decode raises both requests.
                cnt_d = 16'd0;
                if (d_write)     state_d = S_DATA_WR;
                else if (d_read) state_d = S_DATA_RD;
                else             state_d = S_WB;
            end
            S_DATA_RD: begin
                req_c  = 1'b1;
                addr_c = d_addr;
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (expired) state_d = S_HALT;
                end
            end
            S_DATA_WR: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = d_addr;
                wdata_c = d_wdata;
                wstrb_c = d_wstrb;
                if (bus.mem_ready) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (expired) state_d = S_HALT;
                end
            end
            S_WB: begin
                commit_c = 1'b1;
                cnt_d    = 16'd0;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Request and commit are masked while reset is held so an abandoned access drops at once.
    assign bus.mem_req   = req_c & ~rst;
    assign bus.mem_we    = we_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.mem_wstrb = wstrb_c;
    assign commit        = commit_c & ~rst;
    assign bus_err       = (state_q == S_HALT);
    assign instr         = instr_q;
    assign d_rdata       = rdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: a negedge monitor pops expected handshakes and commits
// from exp_q, while the stimulus thread also checks cycle-exact outputs.
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] instr;
    logic [31:0] d_rdata;
    logic        commit;
    logic        bus_err;
    logic [2:0]  dbg_state;

    mem_sequencer_if bus_if ();

    mem_sequencer #(
        .TIMEOUT   (4),
        .NOP_INSTR (32'h00000013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .instr     (instr),
        .d_rdata   (d_rdata),
        .commit    (commit),
        .bus_err   (bus_err),
        .dbg_state (dbg_state),
        .bus       (bus_if.master)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [71:0] exp_q[$];

    function automatic logic [71:0] mk_req(input logic we, input logic [31:0] a,
                                           input logic [31:0] w, input logic [3:0] s);
        return {2'b10, we, a, w, s, 1'b0};
    endfunction

    function automatic logic [71:0] mk_commit(input logic [31:0] i, input logic [31:0] r);
        return {2'b01, i, r, 6'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input string name, input logic [71:0] act);
        logic [71:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event %h at %0t", name, act, $time);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic        pend = 1'b0;
    logic [68:0] pend_v;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.mem_req && bus_if.mem_ready)
                sb_pop("handshake", mk_req(bus_if.mem_we, bus_if.mem_addr,
                                           bus_if.mem_wdata, bus_if.mem_wstrb));
            if (commit)
                sb_pop("commit", mk_commit(instr, d_rdata));
            if (pend && bus_if.mem_req) begin
                total++;
                if ({bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.mem_wstrb} !== pend_v) begin
                    bad++;
                    $display("FAIL req_stable: got %h expected %h at %0t",
                             {bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.mem_wstrb},
                             pend_v, $time);
                end
            end
            pend   = bus_if.mem_req && !bus_if.mem_ready;
            pend_v = {bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.mem_wstrb};
        end else begin
            pend = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic fetch0(input logic [31:0] a, input logic [31:0] word);
        next_cycle();
        pc               = a;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = word;
        exp_q.push_back(mk_req(1'b0, a, 32'd0, 4'd0));
        settle();
        chk("fetch_req", bus_if.mem_req, 1'b1);
        chk("fetch_addr", bus_if.mem_addr, a);
        chk("fetch_commit", commit, 1'b0);
    endtask

    task automatic exec_cycle(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] w, input logic [3:0] s,
                              input logic [31:0] exp_instr);
        next_cycle();
        bus_if.mem_ready = 1'b0;
        d_read  = rd;
        d_write = wr;
        d_addr  = a;
        d_wdata = w;
        d_wstrb = s;
        settle();
        chk("exec_instr", instr, exp_instr);
        chk("exec_req", bus_if.mem_req, 1'b0);
        chk("exec_commit", commit, 1'b0);
    endtask

    task automatic wb_cycle(input logic [31:0] exp_rdata);
        next_cycle();
        bus_if.mem_ready = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        settle();
        chk("wb_commit", commit, 1'b1);
        chk("wb_req", bus_if.mem_req, 1'b0);
        chk("wb_rdata", d_rdata, exp_rdata);
    endtask

    task automatic data_wait(input logic we, input logic [31:0] a, input logic [31:0] w,
                             input logic [3:0] s, input logic rdy, input logic [31:0] rdat);
        next_cycle();
        bus_if.mem_ready = rdy;
        bus_if.mem_rdata = rdat;
        settle();
        chk("data_req", bus_if.mem_req, 1'b1);
        chk("data_we", bus_if.mem_we, we);
        chk("data_addr", bus_if.mem_addr, a);
        chk("data_wdata", bus_if.mem_wdata, w);
        chk("data_wstrb", {28'd0, bus_if.mem_wstrb}, {28'd0, s});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        pc = 32'd0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_addr = 32'd0;
        d_wdata = 32'd0;
        d_wstrb = 4'd0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'd0;

        next_cycle();
        settle();
        chk("rst_req", bus_if.mem_req, 1'b0);
        chk("rst_commit", commit, 1'b0);
        next_cycle();
        settle();
        chk("rst_instr", instr, 32'h00000013);
        chk("rst_rdata", d_rdata, 32'd0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_req2", bus_if.mem_req, 1'b0);

        // ALU instruction, zero-wait: 3 cycles
        rst = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h00500093;
        exp_q.push_back(mk_req(1'b0, 32'd0, 32'd0, 4'd0));
        settle();
        chk("t1_req", bus_if.mem_req, 1'b1);
        chk("t1_addr", bus_if.mem_addr, 32'd0);
        chk("t1_we", bus_if.mem_we, 1'b0);
        exp_q.push_back(mk_commit(32'h00500093, 32'd0));
        exec_cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'h00500093);
        wb_cycle(32'd0);

        // Load with 3 data wait states: ready lands on the 4th (TIMEOUT) request cycle
        fetch0(32'h4, 32'h10002083);
        exp_q.push_back(mk_req(1'b0, 32'h100, 32'd0, 4'd0));
        exp_q.push_back(mk_commit(32'h10002083, 32'hDEADBEEF));
        exec_cycle(1'b1, 1'b0, 32'h100, 32'd0, 4'd0, 32'h10002083);
        for (int i = 0; i < 3; i++)
            data_wait(1'b0, 32'h100, 32'd0, 4'd0, 1'b0, 32'd0);
        data_wait(1'b0, 32'h100, 32'd0, 4'd0, 1'b1, 32'hDEADBEEF);
        chk("t2_rdata_hold", d_rdata, 32'd0);
        wb_cycle(32'hDEADBEEF);
        chk("t2_bus_err", bus_err, 1'b0);

        // Store with one wait state
        fetch0(32'h8, 32'h00112223);
        exp_q.push_back(mk_req(1'b1, 32'h204, 32'h12345678, 4'b0011));
        exp_q.push_back(mk_commit(32'h00112223, 32'hDEADBEEF));
        exec_cycle(1'b0, 1'b1, 32'h204, 32'h12345678, 4'b0011, 32'h00112223);
        data_wait(1'b1, 32'h204, 32'h12345678, 4'b0011, 1'b0, 32'd0);
        data_wait(1'b1, 32'h204, 32'h12345678, 4'b0011, 1'b1, 32'd0);
        wb_cycle(32'hDEADBEEF);

        // Read and write together: write wins, d_rdata untouched
        fetch0(32'hC, 32'h0041a023);
        exp_q.push_back(mk_req(1'b1, 32'h300, 32'hCAFEF00D, 4'hF));
        exp_q.push_back(mk_commit(32'h0041a023, 32'hDEADBEEF));
        exec_cycle(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 4'hF, 32'h0041a023);
        data_wait(1'b1, 32'h300, 32'hCAFEF00D, 4'hF, 1'b1, 32'h11111111);
        wb_cycle(32'hDEADBEEF);

        // Fetch answered exactly on the TIMEOUT cycle
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            pc = 32'h10;
            bus_if.mem_ready = 1'b0;
            settle();
            chk("t6_req", bus_if.mem_req, 1'b1);
            chk("t6_bus_err", bus_err, 1'b0);
        end
        next_cycle();
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h00700113;
        exp_q.push_back(mk_req(1'b0, 32'h10, 32'd0, 4'd0));
        settle();
        exp_q.push_back(mk_commit(32'h00700113, 32'hDEADBEEF));
        exec_cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'h00700113);
        chk("t6_bus_err_exec", bus_err, 1'b0);
        wb_cycle(32'hDEADBEEF);

        // Reset while a store waits
        fetch0(32'h14, 32'h00a12023);
        exec_cycle(1'b0, 1'b1, 32'h400, 32'h55AA55AA, 4'hF, 32'h00a12023);
        data_wait(1'b1, 32'h400, 32'h55AA55AA, 4'hF, 1'b0, 32'd0);
        next_cycle();
        rst = 1'b1;
        d_write = 1'b0;
        settle();
        chk("t7_req_in_rst", bus_if.mem_req, 1'b0);
        chk("t7_commit_in_rst", commit, 1'b0);
        next_cycle();
        rst = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h00900193;
        exp_q.push_back(mk_req(1'b0, 32'h14, 32'd0, 4'd0));
        settle();
        chk("t7_instr", instr, 32'h00000013);
        chk("t7_rdata", d_rdata, 32'd0);
        chk("t7_bus_err", bus_err, 1'b0);
        chk("t7_commit", commit, 1'b0);
        chk("t7_refetch_addr", bus_if.mem_addr, 32'h14);
        exp_q.push_back(mk_commit(32'h00900193, 32'd0));
        exec_cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'h00900193);
        wb_cycle(32'd0);

        // Fetch never answered: HALT after 4 request cycles
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            pc = 32'h18;
            bus_if.mem_ready = 1'b0;
            settle();
            chk("t5_req", bus_if.mem_req, 1'b1);
            chk("t5_addr", bus_if.mem_addr, 32'h18);
            chk("t5_bus_err_pre", bus_err, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus_if.mem_ready = (i != 0);
            settle();
            chk("t5_bus_err", bus_err, 1'b1);
            chk("t5_req_halt", bus_if.mem_req, 1'b0);
            chk("t5_commit_halt", commit, 1'b0);
        end
        next_cycle();
        rst = 1'b1;
        bus_if.mem_ready = 1'b0;
        next_cycle();
        settle();
        chk("t5_bus_err_cleared", bus_err, 1'b0);
        chk("t5_instr_reset", instr, 32'h00000013);

        next_cycle();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Multi-phase sequencer that lets the single-cycle RV32I datapath run over one shared, handshaked memory port. Instruction fetch and data load/store share that port.
- Fetches the instruction at pc and holds it stable for decode. When decode raises mem_read or mem_write, issues the data access, then emits a one-cycle commit strobe.
- The commit strobe gates the pc update and the register-file write enable.
- Sits between the core (pc register, decode/control, ALU address, store data) and the memory/bus interface.

Parameters:
- TIMEOUT, 255: maximum cycles a memory request may stay outstanding before bus_err; valid range 1..65535.
- NOP_INSTR, 32'h00000013: instruction value presented after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- pc  in  32  current program counter; fetch address
- d_read  in  1  load request from control decode of instr
- d_write  in  1  store request from control decode of instr
- d_addr  in  32  data address (ALU result)
- d_wdata  in  32  store data, already lane-aligned
- d_wstrb  in  4  store byte enables
- instr  out  32  registered fetched instruction, to decode
- d_rdata  out  32  registered load data, to write-back mux
- commit  out  1  one-cycle strobe: update pc, permit reg_write
- bus_err  out  1  sticky timeout flag
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  byte enables (4'b0000 on reads)
- mem_ready  in  1  memory accepts/completes the request this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1 on a read

Behaviour:

Reset (rst=1 at a rising edge):
- state=FETCH, instr=NOP_INSTR, d_rdata=0, bus_err=0, timeout counter=0.
- commit=0 and mem_req=0 while rst is high.
- Reset mid-transaction abandons the request; the memory must tolerate a dropped mem_req.

States:
- FETCH
  - Drives mem_req=1, mem_we=0, mem_addr=pc, mem_wstrb=0, mem_wdata=0.
  - On mem_ready: instr<=mem_rdata; go to EXEC.
- EXEC
  - mem_req=0; instr is stable so decode settles.
  - If d_write: go to DATA_WR.
  - Else if d_read: go to DATA_RD.
  - Else: go to WB.
  - d_read and d_write both high: the write wins and the read is ignored.
- DATA_RD
  - Drives mem_req=1, mem_we=0, mem_addr=d_addr, mem_wstrb=0.
  - On mem_ready: d_rdata<=mem_rdata; go to WB.
- DATA_WR
  - Drives mem_req=1, mem_we=1, mem_addr=d_addr, mem_wdata=d_wdata, mem_wstrb=d_wstrb.
  - On mem_ready: go to WB.
- WB
  - commit=1 for exactly this cycle; go to FETCH.
- HALT
  - mem_req=0, commit=0, bus_err=1. Stays here until rst.

Handshake:
- While mem_req=1, mem_addr, mem_we, mem_wdata and mem_wstrb hold stable until the cycle mem_ready=1.
- mem_ready is sampled only in FETCH, DATA_RD and DATA_WR; it is ignored in every other state.

Timeout:
- The counter clears on entry to FETCH, DATA_RD and DATA_WR, and increments each cycle mem_req=1 && mem_ready=0.
- When the counter reaches TIMEOUT with no mem_ready, go to HALT.
- mem_ready arriving in the same cycle the count reaches TIMEOUT counts as success, not a timeout.

Timing with zero-wait memory (mem_ready=1 in the request cycle):
- ALU/branch/jump/lui/auipc: 3 cycles per instruction.
- Load/store: 4 cycles per instruction.
- Each wait cycle adds 1 cycle.

Other rules:
- commit is never asserted twice without an intervening FETCH completion.
- instr and d_rdata change only on mem_ready in their own states.
- pc must hold stable except on the edge after commit; the core guarantees this.
- Misaligned addresses pass through unchecked.
- Instruction-fetch and data accesses are never concurrent. No request reordering, no buffering beyond one instruction and one load word.

Test Plan:
1. Reset then zero-wait memory returning 32'h00500093 (addi) at pc=0 -> mem_req/mem_addr=0 in cycle 1, instr=32'h00500093 from cycle 2, commit high in cycle 3 only, mem_req=0 in cycles 2–3.
2. Load, d_addr=32'h100, memory 3 wait states on data, returns 32'hDEADBEEF -> mem_addr=32'h100 and mem_we=0 held for 4 cycles, d_rdata=32'hDEADBEEF the cycle after mem_ready, commit one cycle later, total 7 cycles.
3. Store, d_addr=32'h204, d_wdata=32'h12345678, d_wstrb=4'b0011 -> one DATA_WR request with mem_we=1 and exact addr/data/strobe, held until mem_ready, then commit, then fetch at the next pc.
4. d_read=1 and d_write=1 simultaneously in EXEC -> only a write request issued, d_rdata unchanged.
5. TIMEOUT=4, mem_ready held 0 during FETCH -> after 4 request cycles enters HALT: bus_err=1 sticky, mem_req=0, commit never rises.
6. Additional case: mem_ready arrives exactly on the TIMEOUT cycle -> instruction accepted, no bus_err.
7. rst asserted during a DATA_WR wait -> next cycle mem_req=0, instr=32'h00000013, d_rdata=0, bus_err=0; after release, fetch restarts at the current pc with no commit pulse.
